// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte master engine.
package i2c_pkg;

    typedef enum logic [1:0] {
        I2C_OP_START = 2'd0,
        I2C_OP_WRITE = 2'd1,
        I2C_OP_READ  = 2'd2,
        I2C_OP_STOP  = 2'd3
    } i2c_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } i2c_state_e;

    localparam int BYTE_QUARTERS = 36;

    // Data/ACK bit cell: SCL is pulled low in the first and last quarter.
    function automatic logic bit_scl_oe(input logic [1:0] q);
        return (q == 2'd0) || (q == 2'd3);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit divider: counts 0..i_div and pulses o_tick on the last cycle of each quarter.
module i2c_quarter_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_hold,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_run && !i_hold && (r_cnt == i_div);

    // A held quarter restarts from zero once the hold releases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_run || i_hold || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / WRITE / READ / STOP commands driving open-drain SCL/SDA.
// Optional slave clock stretching is compiled in with I2C_CLK_STRETCH_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command, bus lines hold their last values
// ST_START | 4 quarters generating a (repeated) START condition
// ST_BITS  | 8 data bits, MSB first, 4 quarters each
// ST_ACK   | 1 acknowledge bit, 4 quarters
// ST_STOP  | 4 quarters generating a STOP condition
// ST_DONE  | one-cycle response pulse, next command may be accepted
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [7:0]       cmd_data_i,
    input  logic             cmd_ack_i,
    output logic             rsp_valid_o,
    output logic [7:0]       rsp_data_o,
    output logic             rsp_nack_o,
    output logic             busy_o,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe_o,
    output logic             sda_oe_o
);

    i2c_state_e       r_state, w_state_n;
    logic [1:0]       r_q, w_q_n;
    logic [2:0]       r_bit, w_bit_n;
    i2c_op_e          r_op, w_op;
    logic [7:0]       r_data, w_data;
    logic             r_ack, w_ack;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_rd;
    logic             r_nack;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_nack;
    logic             r_scl_oe, r_sda_oe;
    logic             w_scl_oe_n, w_sda_oe_n;
    logic             w_accept, w_busy, w_tick, w_hold, w_sample;

    assign cmd_ready_o = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_busy      = !cmd_ready_o;
    assign busy_o      = w_busy;
    assign rsp_valid_o = (r_state == ST_DONE);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_nack_o  = r_rsp_nack;
    assign scl_oe_o    = r_scl_oe;
    assign sda_oe_o    = r_sda_oe;

    assign w_accept = cmd_valid_i && cmd_ready_o;
    assign w_op     = w_accept ? i2c_op_e'(cmd_op_i) : r_op;
    assign w_data   = w_accept ? cmd_data_i : r_data;
    assign w_ack    = w_accept ? cmd_ack_i : r_ack;
    assign w_sample = w_tick && (r_q == 2'd1);

`ifdef I2C_CLK_STRETCH_EN
    assign w_hold = !r_scl_oe && !scl_i;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_i;
    assign w_hold       = 1'b0;
`endif

    i2c_quarter_tick #(.DIV_W(DIV_W)) u_tick (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_run  (w_busy),
        .i_hold (w_hold),
        .i_div  (r_div),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_n = r_state;
        w_q_n     = r_q;
        w_bit_n   = r_bit;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE) w_state_n = ST_IDLE;
                if (w_accept) begin
                    w_q_n   = 2'd0;
                    w_bit_n = 3'd0;
                    case (w_op)
                        I2C_OP_START: w_state_n = ST_START;
                        I2C_OP_STOP:  w_state_n = ST_STOP;
                        default:      w_state_n = ST_BITS;
                    endcase
                end
            end
            ST_BITS: begin
                if (w_tick) begin
                    w_q_n = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_bit == 3'd7) w_state_n = ST_ACK;
                        else               w_bit_n   = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                if (w_tick) begin
                    w_q_n = r_q + 2'd1;
                    if (r_q == 2'd3) w_state_n = ST_DONE;
                end
            end
        endcase
    end

    // Pad enables are derived from the upcoming state so they change exactly at quarter boundaries.
    always_comb begin
        w_scl_oe_n = r_scl_oe;
        w_sda_oe_n = r_sda_oe;
        case (w_state_n)
            ST_START: begin
                w_scl_oe_n = (w_q_n == 2'd3);
                w_sda_oe_n = (w_q_n != 2'd0);
            end
            ST_STOP: begin
                w_scl_oe_n = (w_q_n == 2'd0);
                w_sda_oe_n = !w_q_n[1];
            end
            ST_BITS: begin
                w_scl_oe_n = bit_scl_oe(w_q_n);
                w_sda_oe_n = (w_op == I2C_OP_WRITE) && !w_data[3'd7 - w_bit_n];
            end
            ST_ACK: begin
                w_scl_oe_n = bit_scl_oe(w_q_n);
                w_sda_oe_n = (w_op == I2C_OP_READ) && w_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_op       <= I2C_OP_START;
            r_data     <= 8'd0;
            r_ack      <= 1'b0;
            r_div      <= '0;
            r_rd       <= 8'd0;
            r_nack     <= 1'b0;
            r_rsp_data <= 8'd0;
            r_rsp_nack <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_q      <= w_q_n;
            r_bit    <= w_bit_n;
            r_scl_oe <= w_scl_oe_n;
            r_sda_oe <= w_sda_oe_n;
            if (w_accept) begin
                r_op   <= w_op;
                r_data <= cmd_data_i;
                r_ack  <= cmd_ack_i;
                r_div  <= clk_div_i;
            end
            if (w_sample && (r_state == ST_BITS)) r_rd   <= {r_rd[6:0], sda_i};
            if (w_sample && (r_state == ST_ACK))  r_nack <= sda_i;
            if (w_busy && (w_state_n == ST_DONE)) begin
                r_rsp_data <= (r_op == I2C_OP_READ)  ? r_rd   : 8'd0;
                r_rsp_nack <= (r_op == I2C_OP_WRITE) && r_nack;
            end
        end
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C master engine: executes START / WRITE-byte / READ-byte / STOP commands and drives open-drain SCL/SDA.
- Sits directly below the LUT-driven configuration sequencer that programs the ADV7511 (device address 0x72) over the HDMI transmitter's I2C bus.
- Sequencer issues one command at a time through a valid/ready handshake and receives one response per command.
- Pad tristating is done at top level: oe=1 means pull line low, oe=0 means release.

Parameters:
- DIV_W, 16, width of quarter-bit divider input.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- clk_div_i  in  DIV_W  quarter-bit period minus one, in clk_i cycles (Q = clk_div_i+1)
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  engine idle, accepts command
- cmd_op_i  in  2  0=START, 1=WRITE, 2=READ, 3=STOP
- cmd_data_i  in  8  byte to write (WRITE only)
- cmd_ack_i  in  1  READ only: 1 = master ACKs (drives SDA low), 0 = master NACKs
- rsp_valid_o  out  1  one-cycle pulse, command complete
- rsp_data_o  out  8  byte read (READ); 0 for other ops
- rsp_nack_o  out  1  WRITE: slave NACKed; 0 for other ops
- busy_o  out  1  command in progress
- scl_i  in  1  SCL pad readback
- sda_i  in  1  SDA pad readback
- scl_oe_o  out  1  drive SCL low
- sda_oe_o  out  1  drive SDA low

Behaviour:
- Reset (synchronous, active-high, from any state, including mid-byte):
  - scl_oe_o=0, sda_oe_o=0 (bus released); state IDLE.
  - cmd_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_nack_o=0.
  - No STOP is generated on reset.
- Handshake:
  - Command accepted on the cycle where cmd_valid_i && cmd_ready_o.
  - cmd_op_i, cmd_data_i, cmd_ack_i and clk_div_i are latched at accept.
  - cmd_ready_o=0 and busy_o=1 from the next cycle until completion.
- States: IDLE, START, BITS, ACK, STOP, DONE.
  - START: 4 quarters; SCL/SDA per quarter = (1,1),(1,0),(1,0),(0,0).
  - STOP: 4 quarters; SCL/SDA per quarter = (0,0),(1,0),(1,1),(1,1).
  - BITS: 8 bits, MSB first.
  - ACK: 1 bit.
- Bit cell: 4 quarters; SCL = 0,1,1,0.
  - SDA is set at the start of q0 and held for all 4 quarters.
  - Sample point: sda_i is sampled on the last clk_i cycle of q1.
- WRITE:
  - BITS drives cmd_data_i bits.
  - ACK releases SDA; rsp_nack_o = sampled sda_i.
- READ:
  - BITS releases SDA and shifts sampled bits into rsp_data_o.
  - ACK drives SDA low iff cmd_ack_i=1.
- Durations, excluding the accept cycle:
  - START/STOP: exactly 4Q cycles.
  - WRITE/READ: exactly 36Q cycles.
- Completion:
  - DONE lasts one cycle: rsp_valid_o=1 and cmd_ready_o=1 together, then IDLE.
  - A new command may be accepted in the DONE cycle.
- Outputs between commands:
  - scl_oe_o/sda_oe_o hold their last values (after START or a byte, SCL stays low).
  - After STOP both lines are released.
- rsp_data_o/rsp_nack_o hold until the next DONE.
- Divider:
  - Quarter counter counts 0..Q-1, reloaded each quarter.
  - clk_div_i=0 gives Q=1; this is legal.
  - Changes to clk_div_i mid-command are ignored.
- Not supported: multi-master arbitration, 10-bit addressing.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Enabled:
  - On any quarter where SCL is released (scl_oe_o=0), the quarter counter holds at 0 while scl_i=0 (slave stretching).
  - Durations grow by the stretch time.
- Disabled:
  - scl_i is unused and durations are exact.

Decomposition:
- Shared package i2c_pkg:
  - Op enum (I2C_OP_START/WRITE/READ/STOP).
  - FSM state enum.
  - Constant BYTE_QUARTERS=36.
- One natural sub-module, i2c_quarter_tick:
  - Divider; emits a one-cycle tick at the end of each quarter.
  - Takes a hold input used by clock stretching.

Test Plan:
- clk_div_i=1, START then WRITE 0x72 with slave pulling SDA low during ACK:
  - SDA at each q1 sample = 0,1,1,1,0,0,1,0.
  - rsp_valid_o 72 cycles after the WRITE accept; rsp_nack_o=0.
- WRITE 0x98 with SDA left high at ACK -> rsp_nack_o=1, rsp_data_o=0.
- READ, slave drives 0xA5, cmd_ack_i=0:
  - rsp_data_o=0xA5.
  - sda_oe_o=0 through all 9 bits.
- READ with cmd_ack_i=1 -> sda_oe_o=1 for all 4 quarters of the ACK bit.
- Back-to-back: cmd_valid_i held high with START, WRITE, STOP queued:
  - Each next command accepted in the DONE cycle.
  - Final state SCL=SDA released.
- rst_i asserted at bit 4 of a WRITE (clk_div_i=3):
  - Next cycle: both oe=0, cmd_ready_o=1, no rsp_valid_o.
- With I2C_CLK_STRETCH_EN: hold scl_i=0 for 20 cycles in bit 2 q1 -> WRITE completes in 36Q+20 cycles.
